// File: rtl/mux_ndff_pkg.sv
// Shared definitions for the mux-ndff crossing: launcher FSM states and the
// bus width the launcher and capture stage must agree on.
package mux_ndff_pkg;

  localparam int unsigned DEFAULT_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } tx_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mux_ndff_tx.sv
// Source-domain launcher for the mux-ndff crossing: holds the data bus and
// emits one fixed-width en pulse plus a fixed low gap per accepted word.
module mux_ndff_tx
  import mux_ndff_pkg::*;
#(
  parameter int unsigned DW         = DEFAULT_DW,
  parameter int unsigned EN_CYCLES  = 3,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] data,
  output logic          en,
  output logic          busy
);

  localparam int unsigned CW = $clog2(max_u(EN_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] EN_LOAD  = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  generate
    if (EN_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
      $error("mux_ndff_tx: EN_CYCLES and GAP_CYCLES must both be at least 1");
    end
  endgenerate

  tx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] data_n;
  logic          en_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      en    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      data  <= data_n;
      en    <= en_n;
    end
  end

  // data and en are registered so nothing combinational reaches the crossing
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data;
    en_n    = en;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_n  = in_data;
          en_n    = 1'b1;
          cnt_n   = EN_LOAD;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          en_n    = 1'b0;
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        en_n    = 1'b0;
      end
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

endmodule

// File: tb/tb_mux_ndff_tx.sv
// Bench for mux_ndff_tx across three EN/GAP configurations: per-cycle timing
// model plus a word scoreboard checked on every en rising edge.
module tb_mux_ndff_tx;

  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  task automatic check(input string name, input int inst, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [cfg %0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int EN     = (g == 0) ? 3 : (g == 1) ? 1 : 5;
    localparam int GAP    = (g == 0) ? 3 : (g == 1) ? 1 : 2;
    localparam int PERIOD = EN + GAP + 1;

    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, en, busy;
    logic [7:0] data;

    mux_ndff_tx #(.DW(8), .EN_CYCLES(EN), .GAP_CYCLES(GAP)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .data     (data),
      .en       (en),
      .busy     (busy)
    );

    // Reference model: cycles remaining until the launcher is free again.
    int unsigned busy_left = 0;
    logic [7:0]  exp_data  = '0;
    logic        last_acc  = 1'b0;
    logic [7:0]  sb[$];

    task automatic step(input logic r, input logic v, input logic [7:0] d);
      @(negedge clk);
      check("in_ready", g, in_ready, busy_left == 0);
      check("busy", g, busy, busy_left != 0);
      check("en_level", g, en, busy_left > GAP);
      check("data_hold", g, data, exp_data);
      rstn     = r;
      in_valid = v;
      in_data  = d;
      last_acc = 1'b0;
      if (!r) begin
        busy_left = 0;
        exp_data  = '0;
        sb.delete();
      end else if (v && busy_left == 0) begin
        sb.push_back(d);
        exp_data  = d;
        busy_left = EN + GAP;
        last_acc  = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    endtask

    task automatic settle();
      repeat (PERIOD + 1) step(1'b1, 1'b0, 8'($urandom));
    endtask

    initial begin
      logic [7:0] words [3];
      int idx;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

      repeat (4) step(1'b0, 1'b1, 8'hFF);
      step(1'b1, 1'b1, 8'hFF);
      step(1'b1, 1'b0, 8'h00);
      settle();

      step(1'b1, 1'b1, 8'hA5);
      settle();

      idx = 0;
      for (int i = 0; i < 3 * PERIOD + 4 && idx < 3; i++) begin
        step(1'b1, 1'b1, words[idx]);
        if (last_acc) idx++;
      end
      check("b2b_all_accepted", g, idx, 3);
      settle();

      step(1'b1, 1'b1, 8'h77);
      step(1'b1, 1'b1, 8'h55);
      step(1'b1, 1'b0, 8'h00);
      settle();

      step(1'b1, 1'b1, 8'hC3);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      #1;
      check("async_rst_en", g, en, 0);
      check("async_rst_data", g, data, 0);
      check("async_rst_ready", g, in_ready, 1);
      step(1'b0, 1'b1, 8'h99);
      step(1'b1, 1'b1, 8'h3C);
      step(1'b1, 1'b0, 8'h00);
      settle();

      for (int i = 0; i < 1500; i++) begin
        step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), 8'($urandom));
      end
      settle();
      done_count++;
    end

    int         prev_en   = 0;
    int         hi        = 0;
    longint     cyc       = 0;
    longint     last_rise = -1;
    logic [7:0] held      = '0;

    always @(negedge clk) begin
      if (!rstn) begin
        prev_en   = 0;
        hi        = 0;
        last_rise = -1;
      end else begin
        if (en && prev_en == 0) begin
          if (sb.size() == 0) begin
            check("rise_with_word_pending", g, 0, 1);
          end else begin
            check("rise_data", g, data, sb.pop_front());
          end
          if (last_rise >= 0) check("rise_interval_ok", g, (cyc - last_rise) >= PERIOD, 1);
          last_rise = cyc;
          held      = data;
          hi        = 1;
        end else if (en) begin
          hi++;
          check("data_stable_in_pulse", g, data, held);
        end else if (prev_en != 0) begin
          check("pulse_width", g, hi, EN);
        end
        prev_en = en ? 1 : 0;
      end
      cyc++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && done_count < NCFG; i++) @(posedge clk);
    if (done_count < NCFG) check("timeout_all_done", 0, done_count, NCFG);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
